// File: rtl/compfree_pkg.sv
// Shared types and helpers for the comparison-free streaming sorter.
// Helpers operate on a fixed MAX_ELEMENTS-wide vector, so ELEMENT_NUM may not exceed 256.
package compfree_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int MAX_ELEMENTS = 256;
    localparam int MAX_IDX_W    = 8;

    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_ELEMENTS-1:0] vec);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_ELEMENTS - 1; i >= 0; i--) begin
            if (vec[i[MAX_IDX_W-1:0]]) idx = i[MAX_IDX_W-1:0];
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [MAX_ELEMENTS-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_ELEMENTS'(1))) == '0);
    endfunction

endpackage

// File: rtl/compfree_column.sv
// One bit-column of the elimination chain: keep candidates holding a 0 in this column,
// unless that would eliminate every candidate.
module compfree_column
    import compfree_pkg::*;
#(
    parameter int ELEMENT_NUM = 32
) (
    input  logic [ELEMENT_NUM-1:0] data_bits,
    input  logic [ELEMENT_NUM-1:0] prev_evt,
    output logic [ELEMENT_NUM-1:0] nxt_evt
);

    logic [ELEMENT_NUM-1:0] zero_cand;

    assign zero_cand = prev_evt & ~data_bits;
    assign nxt_evt   = (zero_cand != '0) ? zero_cand : prev_evt;

endmodule

// File: rtl/compfree_sort_stream.sv
// Streams the indices of one latched frame in sorted order, one per accepted beat.
// Build option: COMPFREE_SIGNED_EN treats keys as two's complement (MSB inverted before filtering).
//
// state | meaning
// IDLE  | waiting for start; frame load happens here
// RUN   | emitting winners while candidates remain
// DRAIN | final beat presented, waiting for its handshake
module compfree_sort_stream
    import compfree_pkg::*;
#(
    parameter int ELEMENT_NUM      = 32,
    parameter int DATA_WIDTH       = 8,
    parameter int LOG2_ELEMENT_NUM = $clog2(ELEMENT_NUM)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [ELEMENT_NUM*DATA_WIDTH-1:0] whole_um,
    input  logic [ELEMENT_NUM-1:0]            valid_mask,
    input  logic                              descend,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LOG2_ELEMENT_NUM-1:0]       out_idx,
    output logic                              out_last,
    output logic                              done
);

    logic [ELEMENT_NUM*DATA_WIDTH-1:0] data_q;
    logic [ELEMENT_NUM-1:0]            evt_q;
    logic                              desc_q;
    state_e                            state_q;

    logic [ELEMENT_NUM-1:0]      final_cand;
    logic [LOG2_ELEMENT_NUM-1:0] win_idx;
    logic                        last_pick;
    logic                        slot_free;

    // Column 0 is the MSB; each column narrows the candidate set handed down by the previous one.
    for (genvar c = 0; c < DATA_WIDTH; c++) begin : g_col
        localparam int BIT = DATA_WIDTH - 1 - c;
`ifdef COMPFREE_SIGNED_EN
        localparam logic FLIP = (c == 0);
`else
        localparam logic FLIP = 1'b0;
`endif
        logic [ELEMENT_NUM-1:0] col_bits;
        logic [ELEMENT_NUM-1:0] prev;
        logic [ELEMENT_NUM-1:0] nxt;

        always_comb begin
            col_bits = '0;
            for (int i = 0; i < ELEMENT_NUM; i++) begin
                col_bits[i] = data_q[i*DATA_WIDTH + BIT] ^ desc_q ^ FLIP;
            end
        end

        if (c == 0) begin : g_head
            assign prev = evt_q;
        end else begin : g_link
            assign prev = g_col[c-1].nxt;
        end

        compfree_column #(
            .ELEMENT_NUM (ELEMENT_NUM)
        ) u_col (
            .data_bits (col_bits),
            .prev_evt  (prev),
            .nxt_evt   (nxt)
        );
    end

    assign final_cand = g_col[DATA_WIDTH-1].nxt;
    assign win_idx    = LOG2_ELEMENT_NUM'(lowest_set_idx(MAX_ELEMENTS'(final_cand)));
    assign last_pick  = is_onehot(MAX_ELEMENTS'(evt_q));
    assign slot_free  = !out_valid || out_ready;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            evt_q     <= '0;
            desc_q    <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q  <= whole_um;
                        evt_q   <= valid_mask;
                        desc_q  <= descend;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // An empty mask yields no beats: report completion straight away.
                    if (evt_q == '0) begin
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end else if (slot_free) begin
                        out_idx   <= win_idx;
                        out_valid <= 1'b1;
                        out_last  <= last_pick;
                        evt_q     <= evt_q & ~(ELEMENT_NUM'(1) << win_idx);
                        if (last_pick) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_compfree_sort_stream.sv
// Self-checking bench for compfree_sort_stream: directed frames plus randomized frames
// checked against a selection-sort reference model.
module tb_compfree_sort_stream;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int LW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [N*DW-1:0] whole_um = '0;
    logic [N-1:0]    valid_mask = '0;
    logic            descend = 1'b0;
    logic            out_ready = 1'b0;
    logic            busy;
    logic            out_valid;
    logic [LW-1:0]   out_idx;
    logic            out_last;
    logic            done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compfree_sort_stream #(
        .ELEMENT_NUM (N),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .whole_um   (whole_um),
        .valid_mask (valid_mask),
        .descend    (descend),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int key_of(input logic [DW-1:0] v);
`ifdef COMPFREE_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    function automatic logic [N*DW-1:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c, input logic [7:0] d);
        logic [N*DW-1:0] um;
        um = '0;
        um[0*DW +: DW] = a;
        um[1*DW +: DW] = b;
        um[2*DW +: DW] = c;
        um[3*DW +: DW] = d;
        return um;
    endfunction

    // bp_mode: 0 = ready always high, 1 = ready low 3 cycles on beat 2, 2 = random ready
    task automatic run_frame(input logic [N*DW-1:0] um, input logic [N-1:0] mask,
                             input logic desc, input int bp_mode, input string tag);
        int exp_q[$];
        logic [N-1:0] rem;
        int best, ki, kb, k, stalls, sz;
        bit fin;

        rem = mask;
        while (rem != '0) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (rem[i]) begin
                    if (best < 0) best = i;
                    else begin
                        ki = key_of(um[i*DW +: DW]);
                        kb = key_of(um[best*DW +: DW]);
                        if (desc ? (ki > kb) : (ki < kb)) best = i;
                    end
                end
            end
            exp_q.push_back(best);
            rem[best] = 1'b0;
        end
        sz = exp_q.size();

        @(negedge clk);
        whole_um   = um;
        valid_mask = mask;
        descend    = desc;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        whole_um   = {$urandom, $urandom};
        valid_mask = N'($urandom);
        descend    = ~desc;

        k = 0;
        stalls = 0;
        fin = 1'b0;
        for (int n = 0; n < 200 && !fin; n++) begin
            if (n > 0) @(negedge clk);
            if (bp_mode == 1 && k == 1 && out_valid && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
            end else if (bp_mode == 2) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            // A start while busy must be ignored (junk data is on whole_um).
            start = (n == 2 && sz >= 2);

            if (n == 0 && sz > 0) begin
                chk({tag, "_busy"}, busy, 1);
                chk({tag, "_early_valid"}, out_valid, 0);
            end
            if (n == 1 && sz > 0) chk({tag, "_latency"}, out_valid, 1);

            if (out_valid) begin
                if (k < sz) begin
                    chk({tag, "_idx"}, out_idx, exp_q[k]);
                    chk({tag, "_last"}, out_last, (k == sz - 1));
                end else begin
                    chk({tag, "_extra_beat"}, k + 1, sz);
                end
                if (out_ready) k++;
            end

            if (done) begin
                chk({tag, "_beats"}, k, sz);
                chk({tag, "_done_busy"}, busy, 0);
                if (bp_mode == 0) chk({tag, "_done_lat"}, n, sz + 1);
                if (bp_mode == 1 && sz >= 2) chk({tag, "_done_lat_bp"}, n, sz + 4);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        if (!fin) chk({tag, "_timeout"}, fin, 1);
        else begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [N*DW-1:0] um;
        logic [N-1:0]    mask;

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(pack4(8'd5, 8'd1, 8'd9, 8'd1), 8'h0F, 1'b0, 0, "asc");
        run_frame(pack4(8'd5, 8'd1, 8'd9, 8'd1), 8'h0F, 1'b1, 0, "desc");
        run_frame(pack4(8'h80, 8'h7F, 8'h00, 8'hFF), 8'h0F, 1'b0, 0, "msb");
        run_frame(pack4(8'h80, 8'h7F, 8'h00, 8'hFF), 8'h0F, 1'b1, 0, "msb_desc");
        run_frame(pack4(8'd5, 8'd1, 8'd9, 8'd1), 8'h05, 1'b0, 0, "mask5");
        run_frame(pack4(8'd5, 8'd1, 8'd9, 8'd1), 8'h00, 1'b0, 0, "mask0");
        run_frame(pack4(8'd5, 8'd1, 8'd9, 8'd1), 8'h0F, 1'b0, 1, "bp");
        run_frame({8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, 8'hFF, 1'b1, 0, "ties");
        run_frame(pack4(8'd7, 8'd2, 8'd0, 8'd0), 8'h02, 1'b0, 0, "single");

        // Reset in the middle of a frame
        @(negedge clk);
        whole_um   = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        valid_mask = 8'hFF;
        descend    = 1'b0;
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(pack4(8'd44, 8'd11, 8'd33, 8'd22), 8'h0F, 1'b0, 0, "post_rst");

        for (int f = 0; f < 40; f++) begin
            um = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < N; i++) um[i*DW +: DW] = um[i*DW +: DW] & 8'hC1;
            end
            case ($urandom_range(0, 5))
                0:       mask = '1;
                1:       mask = '0;
                default: mask = N'($urandom);
            endcase
            run_frame(um, mask, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
